load_store_unit: RTL

Memory-stage block of the pipelined datapath. It takes the EX/MEM operation, runs loads and stores against the data memory over a req/ack handshake, and aligns and extends load data. It holds the pipeline while an access is outstanding and registers the MEM/WB outputs (`memory_data`, `alu_res`, destination register, write enable, select) that feed the write-back mux.

---
 rtl/load_store_unit.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage of the pipeline. Accepts EX/MEM operations,
// drives the data memory over a req/ack handshake with an abort timeout,
// aligns and extends load data, and registers the MEM/WB outputs.
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [31:0] in_alu_res,
   input  logic [4:0]  in_rd,
   input  logic        in_reg_write,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [31:0] memory_data,
   output logic [31:0] alu_res,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic        wb_sel,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic          op_load_q, op_load_d;
   logic [1:0]    op_size_q, op_size_d;
   logic          op_unsigned_q, op_unsigned_d;
   logic [1:0]    op_lo_q, op_lo_d;
   logic [4:0]    op_rd_q, op_rd_d;
   logic          op_reg_write_q, op_reg_write_d;
   logic          wb_valid_q, wb_valid_d;
   logic [31:0]   memory_data_q, memory_data_d;
   logic [31:0]   alu_res_q, alu_res_d;
   logic [4:0]    wb_rd_q, wb_rd_d;
   logic          wb_reg_write_q, wb_reg_write_d;
   logic          wb_sel_q, wb_sel_d;
   logic          misalign_err_q, misalign_err_d;
   logic          bus_err_q, bus_err_d;

   logic          is_mem;
   logic          aligned;
   logic [3:0]    st_be;
   logic [31:0]   st_wdata;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [31:0]   load_ext;
   logic          stall_c;

   // Decode the incoming operation: alignment check and store lane placement
   always_comb begin
      is_mem = in_load | in_store;
      case (in_size)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~in_addr[0];
         default: aligned = (in_addr[1:0] == 2'b00);
      endcase
      st_be    = 4'b1111;
      st_wdata = in_wdata;
      if (!in_load) begin
         case (in_size)
            2'b00: begin
               st_be    = 4'b0001 << in_addr[1:0];
               st_wdata = {4{in_wdata[7:0]}};
            end
            2'b01: begin
               st_be    = 4'b0011 << {in_addr[1], 1'b0};
               st_wdata = {2{in_wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // Pick the addressed lane out of the returned word and sign/zero extend it
   always_comb begin
      case (op_lo_q)
         2'd0:    rd_byte = mem_rdata[7:0];
         2'd1:    rd_byte = mem_rdata[15:8];
         2'd2:    rd_byte = mem_rdata[23:16];
         default: rd_byte = mem_rdata[31:24];
      endcase
      rd_half = op_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (op_size_q)
         2'b00:   load_ext = {{24{~op_unsigned_q & rd_byte[7]}}, rd_byte};
         2'b01:   load_ext = {{16{~op_unsigned_q & rd_half[15]}}, rd_half};
         default: load_ext = mem_rdata;
      endcase
   end

   // Next-state logic: accept, wait for ack or timeout, and fill the MEM/WB slot
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      mem_be_d       = mem_be_q;
      op_load_d      = op_load_q;
      op_size_d      = op_size_q;
      op_unsigned_d  = op_unsigned_q;
      op_lo_d        = op_lo_q;
      op_rd_d        = op_rd_q;
      op_reg_write_d = op_reg_write_q;
      memory_data_d  = memory_data_q;
      alu_res_d      = alu_res_q;
      wb_rd_d        = wb_rd_q;
      wb_sel_d       = wb_sel_q;
      wb_valid_d     = 1'b0;
      wb_reg_write_d = 1'b0;
      misalign_err_d = 1'b0;
      bus_err_d      = 1'b0;
      stall_c        = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (!is_mem) begin
                  wb_valid_d     = 1'b1;
                  wb_sel_d       = 1'b1;
                  wb_rd_d        = in_rd;
                  wb_reg_write_d = in_reg_write;
                  alu_res_d      = in_alu_res;
               end else if (!aligned) begin
                  wb_valid_d     = 1'b1;
                  wb_sel_d       = ~in_load;
                  wb_rd_d        = in_rd;
                  misalign_err_d = 1'b1;
               end else begin
                  stall_c        = 1'b1;
                  state_d        = ACCESS;
                  cnt_d          = '0;
                  mem_req_d      = 1'b1;
                  mem_we_d       = ~in_load;
                  mem_addr_d     = {in_addr[31:2], 2'b00};
                  mem_be_d       = st_be;
                  mem_wdata_d    = st_wdata;
                  op_load_d      = in_load;
                  op_size_d      = in_size;
                  op_unsigned_d  = in_unsigned;
                  op_lo_d        = in_addr[1:0];
                  op_rd_d        = in_rd;
                  op_reg_write_d = in_reg_write;
               end
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               state_d        = IDLE;
               mem_req_d      = 1'b0;
               wb_valid_d     = 1'b1;
               wb_rd_d        = op_rd_q;
               wb_sel_d       = ~op_load_q;
               wb_reg_write_d = op_load_q & op_reg_write_q;
               if (op_load_q) begin
                  memory_data_d = load_ext;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               wb_valid_d = 1'b1;
               wb_rd_d    = op_rd_q;
               wb_sel_d   = ~op_load_q;
               bus_err_d  = 1'b1;
            end else begin
               stall_c = 1'b1;
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         mem_be_q       <= '0;
         op_load_q      <= 1'b0;
         op_size_q      <= '0;
         op_unsigned_q  <= 1'b0;
         op_lo_q        <= '0;
         op_rd_q        <= '0;
         op_reg_write_q <= 1'b0;
         wb_valid_q     <= 1'b0;
         memory_data_q  <= '0;
         alu_res_q      <= '0;
         wb_rd_q        <= '0;
         wb_reg_write_q <= 1'b0;
         wb_sel_q       <= 1'b0;
         misalign_err_q <= 1'b0;
         bus_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         mem_be_q       <= mem_be_d;
         op_load_q      <= op_load_d;
         op_size_q      <= op_size_d;
         op_unsigned_q  <= op_unsigned_d;
         op_lo_q        <= op_lo_d;
         op_rd_q        <= op_rd_d;
         op_reg_write_q <= op_reg_write_d;
         wb_valid_q     <= wb_valid_d;
         memory_data_q  <= memory_data_d;
         alu_res_q      <= alu_res_d;
         wb_rd_q        <= wb_rd_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_sel_q       <= wb_sel_d;
         misalign_err_q <= misalign_err_d;
         bus_err_q      <= bus_err_d;
      end
   end

   assign stall        = stall_c & rst_n;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_be       = mem_be_q;
   assign wb_valid     = wb_valid_q;
   assign memory_data  = memory_data_q;
   assign alu_res      = alu_res_q;
   assign wb_rd        = wb_rd_q;
   assign wb_reg_write = wb_reg_write_q;
   assign wb_sel       = wb_sel_q;
   assign misalign_err = misalign_err_q;
   assign bus_err      = bus_err_q;

endmodule
